// File: rtl/rom_seq_reader.sv
// ============================================================================
// rom_seq_reader : program-address generator for the sequencer instruction ROM
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module rom_seq_reader #(
  parameter int ROM_DEPTH   = 256,
  parameter int JMP_WIDTH   = 8,
  parameter int ROM_LATENCY = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               load_start_i,
  input  logic [31:0]                        start_addr_i,
  input  logic                               cmd_valid_i,
  output logic                               cmd_ready_o,
  input  logic [2:0]                         cmd_op_i,
  input  logic [JMP_WIDTH-1:0]               cmd_arg_i,
  output logic [31:0]                        rom_addr_o,
  output logic                               rom_data_rdy_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_lvl_o,
  output logic [2:0]                         err_o
);

  localparam int ADDR_WIDTH = $clog2(ROM_DEPTH);
  localparam int LVL_WIDTH  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_WIDTH  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [ROM_LATENCY-1:0] PIPE_LOW_MASK = {ROM_LATENCY{1'b1}} >> 1;
  localparam logic [LVL_WIDTH-1:0]   STACK_FULL    = LVL_WIDTH'(STACK_DEPTH);

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JMP_UP   = 3'd1;
  localparam logic [2:0] OP_JMP_DN   = 3'd2;
  localparam logic [2:0] OP_CALL     = 3'd3;
  localparam logic [2:0] OP_RET      = 3'd4;
  localparam logic [2:0] OP_LOOP_SET = 3'd5;
  localparam logic [2:0] OP_LOOP_BR  = 3'd6;

  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [ROM_LATENCY-1:0] pipe_q, pipe_d;
  logic [LVL_WIDTH-1:0]   sp_q, sp_d;
  logic [JMP_WIDTH-1:0]   loop_cnt_q, loop_cnt_d;
  logic [2:0]             err_q, err_d;
  logic [ADDR_WIDTH-1:0]  stack_q [STACK_DEPTH];
  logic [ADDR_WIDTH-1:0]  stack_d [STACK_DEPTH];

  logic                   cmd_fire;
  logic [ADDR_WIDTH-1:0]  arg_addr;
  logic [ADDR_WIDTH-1:0]  addr_inc;
  logic [LVL_WIDTH-1:0]   sp_dec;
  logic                   unused_ok;

  // Only the low address bits of the start address select a ROM word.
  assign unused_ok = &{1'b0, start_addr_i[31:ADDR_WIDTH]};

  // Ready stays low while a fetch is still travelling through the lower pipe stages.
  assign cmd_ready_o = !load_start_i && ((pipe_q & PIPE_LOW_MASK) == '0);
  assign cmd_fire    = cmd_valid_i && cmd_ready_o;
  assign arg_addr    = ADDR_WIDTH'(cmd_arg_i);
  assign addr_inc    = addr_q + ADDR_WIDTH'(1);
  assign sp_dec      = sp_q - LVL_WIDTH'(1);

  always_comb begin
    addr_d     = addr_q;
    pipe_d     = pipe_q << 1;
    sp_d       = sp_q;
    loop_cnt_d = loop_cnt_q;
    err_d      = err_q;
    stack_d    = stack_q;

    if (load_start_i) begin
      addr_d     = start_addr_i[ADDR_WIDTH-1:0];
      pipe_d     = ROM_LATENCY'(1);
      sp_d       = '0;
      loop_cnt_d = '0;
      err_d      = '0;
    end else if (cmd_fire) begin
      pipe_d[0] = 1'b1;
      case (cmd_op_i)
        OP_NEXT:   addr_d = addr_inc;
        OP_JMP_UP: addr_d = addr_q + arg_addr;
        OP_JMP_DN: addr_d = addr_q - arg_addr;
        OP_CALL: begin
          if (sp_q == STACK_FULL) begin
            addr_d   = addr_inc;
            err_d[0] = 1'b1;
          end else begin
            stack_d[sp_q[IDX_WIDTH-1:0]] = addr_inc;
            sp_d   = sp_q + LVL_WIDTH'(1);
            addr_d = arg_addr;
          end
        end
        OP_RET: begin
          if (sp_q == '0) begin
            addr_d   = addr_inc;
            err_d[1] = 1'b1;
          end else begin
            addr_d = stack_q[sp_dec[IDX_WIDTH-1:0]];
            sp_d   = sp_dec;
          end
        end
        OP_LOOP_SET: begin
          loop_cnt_d = cmd_arg_i;
          addr_d     = addr_inc;
        end
        OP_LOOP_BR: begin
          if (loop_cnt_q != '0) begin
            loop_cnt_d = loop_cnt_q - JMP_WIDTH'(1);
            addr_d     = addr_q - arg_addr;
          end else begin
            addr_d = addr_inc;
          end
        end
        default: begin
          addr_d   = addr_inc;
          err_d[2] = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q     <= '0;
      pipe_q     <= '0;
      sp_q       <= '0;
      loop_cnt_q <= '0;
      err_q      <= '0;
    end else begin
      addr_q     <= addr_d;
      pipe_q     <= pipe_d;
      sp_q       <= sp_d;
      loop_cnt_q <= loop_cnt_d;
      err_q      <= err_d;
    end
  end

  // Stack contents are qualified by sp_q, so they need no reset.
  always_ff @(posedge clk_i) begin
    stack_q <= stack_d;
  end

  assign rom_addr_o     = 32'(addr_q);
  assign rom_data_rdy_o = pipe_q[ROM_LATENCY-1];
  assign stack_lvl_o    = sp_q;
  assign err_o          = err_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_seq_reader.sv
// ============================================================================
// tb_rom_seq_reader : scoreboard bench with a queue-based reference model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_rom_seq_reader;

  localparam int DEPTH = 256;
  localparam int JW    = 8;
  localparam int LAT   = 2;
  localparam int SD    = 4;
  localparam int LVLW  = $clog2(SD + 1);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            load_start_i;
  logic [31:0]     start_addr_i;
  logic            cmd_valid_i;
  logic            cmd_ready_o;
  logic [2:0]      cmd_op_i;
  logic [JW-1:0]   cmd_arg_i;
  logic [31:0]     rom_addr_o;
  logic            rom_data_rdy_o;
  logic [LVLW-1:0] stack_lvl_o;
  logic [2:0]      err_o;

  always #5 clk_i = ~clk_i;

  rom_seq_reader #(
    .ROM_DEPTH  (DEPTH),
    .JMP_WIDTH  (JW),
    .ROM_LATENCY(LAT),
    .STACK_DEPTH(SD)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .load_start_i  (load_start_i),
    .start_addr_i  (start_addr_i),
    .cmd_valid_i   (cmd_valid_i),
    .cmd_ready_o   (cmd_ready_o),
    .cmd_op_i      (cmd_op_i),
    .cmd_arg_i     (cmd_arg_i),
    .rom_addr_o    (rom_addr_o),
    .rom_data_rdy_o(rom_data_rdy_o),
    .stack_lvl_o   (stack_lvl_o),
    .err_o         (err_o)
  );

  typedef struct {
    int addr;
    int lvl;
    int err;
    int due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state
  int   m_addr = 0;
  int   m_loop = 0;
  int   m_err  = 0;
  int   m_stk[$];
  int   busy_until = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic void check(input string name, input int act, input int exp_v);
    n_cmp++;
    if (act != exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endfunction

  function automatic int wrap(input int x);
    return ((x % DEPTH) + DEPTH) % DEPTH;
  endfunction

  // A fetch accepted at the coming edge shows its strobe, and frees the
  // command port, once LAT-1 further edges have shifted it to the pipe MSB.
  function automatic void push_fetch();
    exp_t e;
    e.addr = m_addr;
    e.lvl  = m_stk.size();
    e.err  = m_err;
    e.due  = cyc + LAT;
    sb.push_back(e);
    busy_until = cyc + LAT;
  endfunction

  function automatic void drop_in_flight();
    while (sb.size() > 0 && sb[sb.size()-1].due > cyc) void'(sb.pop_back());
  endfunction

  function automatic void model_cmd(input int op, input int arg);
    int a;
    a = arg % DEPTH;
    case (op)
      0: m_addr = wrap(m_addr + 1);
      1: m_addr = wrap(m_addr + a);
      2: m_addr = wrap(m_addr - a);
      3: begin
        if (m_stk.size() < SD) begin
          m_stk.push_back(wrap(m_addr + 1));
          m_addr = a;
        end else begin
          m_addr = wrap(m_addr + 1);
          m_err  = m_err | 1;
        end
      end
      4: begin
        if (m_stk.size() > 0) m_addr = m_stk.pop_back();
        else begin
          m_addr = wrap(m_addr + 1);
          m_err  = m_err | 2;
        end
      end
      5: begin
        m_loop = arg;
        m_addr = wrap(m_addr + 1);
      end
      6: begin
        if (m_loop != 0) begin
          m_loop = m_loop - 1;
          m_addr = wrap(m_addr - a);
        end else m_addr = wrap(m_addr + 1);
      end
      default: begin
        m_addr = wrap(m_addr + 1);
        m_err  = m_err | 4;
      end
    endcase
  endfunction

  // Monitor: every strobe must match the oldest outstanding fetch, on time.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      while (sb.size() > 0 && sb[0].due < cyc) begin
        check("rdy_pulse_missing", 0, 1);
        void'(sb.pop_front());
      end
      if (rom_data_rdy_o === 1'b1) begin
        if (sb.size() == 0) check("rdy_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          check("rdy_cycle", cyc, e.due);
          check("rom_addr", int'(rom_addr_o), e.addr);
          check("stack_lvl", int'(stack_lvl_o), e.lvl);
          check("err", int'(err_o), e.err);
        end
      end
    end
  end

  // One clock of stimulus; entered and left just after a falling edge.
  task automatic step(input bit rst, input bit ld, input logic [31:0] sa,
                      input bit v, input int op, input int arg);
    bit exp_rdy;
    rst_i        = rst;
    load_start_i = ld;
    start_addr_i = sa;
    cmd_valid_i  = v;
    cmd_op_i     = op[2:0];
    cmd_arg_i    = arg[JW-1:0];
    #1;
    exp_rdy = !ld && (cyc >= busy_until);
    if (!rst) check("cmd_ready", int'(cmd_ready_o), int'(exp_rdy));
    if (rst) begin
      m_addr = 0;
      m_loop = 0;
      m_err  = 0;
      m_stk.delete();
      busy_until = 0;
      drop_in_flight();
    end else if (ld) begin
      m_addr = int'(sa & 32'(DEPTH - 1));
      m_loop = 0;
      m_err  = 0;
      m_stk.delete();
      drop_in_flight();
      push_fetch();
    end else if (v && exp_rdy) begin
      model_cmd(op, arg);
      push_fetch();
    end
    @(negedge clk_i);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic load(input logic [31:0] sa);
    step(0, 1, sa, 0, 0, 0);
  endtask

  // Commands offered while the port is busy must be ignored by the DUT.
  task automatic issue(input int op, input int arg);
    while (cyc < busy_until)
      step(0, 0, 32'h0, 1, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    step(0, 0, 32'h0, 1, op, arg);
  endtask

  task automatic check_reset_state();
    check("reset_addr", int'(rom_addr_o), 0);
    check("reset_rdy", int'(rom_data_rdy_o), 0);
    check("reset_lvl", int'(stack_lvl_o), 0);
    check("reset_err", int'(err_o), 0);
  endtask

  initial begin
    int r;
    rst_i        = 1'b1;
    load_start_i = 1'b0;
    start_addr_i = '0;
    cmd_valid_i  = 1'b0;
    cmd_op_i     = '0;
    cmd_arg_i    = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    check_reset_state();

    // Load and back-to-back sequential steps
    load(32'h10);
    for (int i = 0; i < 3; i++) issue(0, 0);
    idle(LAT + 1);

    // Wrap-around in both directions
    load(32'hFF);
    issue(0, 0);
    load(32'h02);
    issue(2, 5);
    load(32'hF0);
    issue(1, 8'h12);

    // Nested calls, overflow, LIFO unwind, underflow
    load(32'h05);
    issue(3, 8'h40);
    issue(3, 8'h50);
    issue(3, 8'h60);
    issue(3, 8'h70);
    issue(3, 8'h80);
    for (int i = 0; i < 4; i++) issue(4, 0);
    issue(4, 0);

    // Hardware loop: body runs four times then falls through
    load(32'h20);
    issue(5, 3);
    for (int i = 0; i < 4; i++) begin
      issue(0, 0);
      issue(6, 1);
    end
    issue(0, 0);

    // Load priority, load during a fetch, reserved opcode
    step(0, 1, 32'h30, 1, 1, 8'h10);
    issue(0, 0);
    load(32'h80);
    idle(LAT + 1);
    issue(7, 0);

    // Reset right after a load suppresses the strobe
    load(32'h44);
    step(1, 0, 32'h0, 0, 0, 0);
    check_reset_state();
    idle(LAT + 1);

    // Randomized mix of commands, loads and resets
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)
        step(1, 0, 32'h0, 0, 0, 0);
      else if (r < 7)
        step(0, 1, $urandom, ($urandom_range(0, 1) == 1), int'($urandom_range(0, 7)), 0);
      else
        step(0, 0, 32'h0, ($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)),
             (r < 90) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 255)));
    end

    idle(LAT + 2);
    check("scoreboard_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
